// File: rtl/alu_result_stage_if.sv
// Bundle between the ALU result stage and its neighbours: the ALU-side
// capture port (in_*) and the register-file writeback port (out_*).
interface alu_result_stage_if #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_result;
  logic              in_carry;
  logic              in_a_msb;
  logic              in_b_msb;
  logic              in_arith;
  logic              in_sub;
  logic [RD_W-1:0]   in_rd;
  logic              in_wen;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [RD_W-1:0]   out_rd;
  logic              out_wen;
  logic [3:0]        out_flags;

  // Environment side: drives ALU results in, consumes writeback entries.
  modport master (
    output in_valid, in_result, in_carry, in_a_msb, in_b_msb,
    output in_arith, in_sub, in_rd, in_wen,
    input  in_ready,
    input  out_valid, out_data, out_rd, out_wen, out_flags,
    output out_ready
  );

  // Stage side.
  modport slave (
    input  in_valid, in_result, in_carry, in_a_msb, in_b_msb,
    input  in_arith, in_sub, in_rd, in_wen,
    output in_ready,
    output out_valid, out_data, out_rd, out_wen, out_flags,
    input  out_ready
  );
endinterface

// File: rtl/alu_result_stage.sv
// ALU result stage: captures result + {N,Z,C,V} and feeds writeback through a
// 2-entry skid buffer. Define ALU_RESULT_FWD_EN to add the fwd_* outputs.
//
//   state    | meaning
//   ---------+-------------------------------------------
//   ST_EMPTY | no entries buffered
//   ST_ONE   | head valid, skid empty
//   ST_FULL  | head and skid valid, upstream stalled
module alu_result_stage #(
  parameter int DATA_W  = 32,
  parameter int RD_W    = 5,
  parameter int DROP_R0 = 1
) (
  input  logic clk,
  input  logic rst_n,
  alu_result_stage_if.slave bus
`ifdef ALU_RESULT_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [RD_W-1:0]   fwd_rd,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  localparam logic DROP_EN = (DROP_R0 != 0);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [RD_W-1:0]   rd;
    logic              wen;
    logic [3:0]        flags;
  } entry_t;

  state_t state;
  state_t next_state;

  entry_t head;
  entry_t skid;
  entry_t new_entry;

  logic in_fire;
  logic out_fire;
  logic load_head_new;
  logic load_skid_new;
  logic load_head_skid;

  logic flag_n;
  logic flag_z;
  logic flag_c;
  logic flag_v;
  logic res_msb;

  // Flags are frozen into the entry at capture so writeback sees them aligned.
  always_comb begin
    res_msb = bus.in_result[DATA_W-1];
    flag_n  = res_msb;
    flag_z  = (bus.in_result == '0);
    flag_c  = bus.in_arith & bus.in_carry;
    flag_v  = 1'b0;
    if (bus.in_arith) begin
      if (bus.in_sub) begin
        flag_v = (bus.in_a_msb != bus.in_b_msb) & (res_msb != bus.in_a_msb);
      end else begin
        flag_v = (bus.in_a_msb == bus.in_b_msb) & (res_msb != bus.in_a_msb);
      end
    end
  end

  always_comb begin
    new_entry       = '0;
    new_entry.data  = bus.in_result;
    new_entry.rd    = bus.in_rd;
    new_entry.wen   = bus.in_wen & ~(DROP_EN & (bus.in_rd == '0));
    new_entry.flags = {flag_n, flag_z, flag_c, flag_v};
  end

  assign bus.in_ready  = (state != ST_FULL) & rst_n;
  assign bus.out_valid = (state != ST_EMPTY);

  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state     = state;
    load_head_new  = 1'b0;
    load_skid_new  = 1'b0;
    load_head_skid = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (in_fire) begin
          next_state    = ST_ONE;
          load_head_new = 1'b1;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          load_head_new = 1'b1;
        end else if (in_fire) begin
          next_state    = ST_FULL;
          load_skid_new = 1'b1;
        end else if (out_fire) begin
          next_state = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          next_state     = ST_ONE;
          load_head_skid = 1'b1;
        end
      end
      default: begin
        next_state = ST_EMPTY;
      end
    endcase
  end

  // Head only changes on a load, so out_* hold while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head <= '0;
      skid <= '0;
    end else begin
      if (load_head_new) begin
        head <= new_entry;
      end else if (load_head_skid) begin
        head <= skid;
      end
      if (load_skid_new) begin
        skid <= new_entry;
      end
    end
  end

  assign bus.out_data  = head.data;
  assign bus.out_rd    = head.rd;
  assign bus.out_wen   = head.wen;
  assign bus.out_flags = head.flags;

`ifdef ALU_RESULT_FWD_EN
  entry_t youngest;
  logic   any_valid;

  assign youngest  = (state == ST_FULL) ? skid : head;
  assign any_valid = (state != ST_EMPTY);

  assign fwd_valid = any_valid & youngest.wen;
  assign fwd_rd    = any_valid ? youngest.rd : '0;
  assign fwd_data  = any_valid ? youngest.data : '0;
`endif

endmodule
